// File: rtl/simframe_pattern_seq.sv
// simframe_pattern_seq
// Pattern source for the simulated-frame generator. It emits one PATTERN_WIDTH word
// per frame on an AXI-Stream master. The sequence is programmable: start value, step
// rule, and frame count (0 means continuous until STOP).
//
// Optional feature: define SIMFRAME_SEQ_GAP_EN to insert GAP_CYCLES idle cycles
// between frames. Without it, words are always sent back-to-back.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   START, STOP         1-cycle control strobes (START latches the configuration)
//   FIRST_PATTERN       first word of the sequence
//   PATTERN_STEP        increment used in mode 0
//   MODE                0=add, 1=rotate-left, 2=invert, 3=hold
//   FRAME_COUNT         frames per run (0 = continuous)
//   GAP_CYCLES          idle cycles between frames (gap build only)
//   AXIS_OUT_*          pattern stream master
//   BUSY                high while a run is active
//   FRAMES_SENT         handshakes completed this run; saturates
module simframe_pattern_seq #(
    parameter int unsigned PATTERN_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     START,
    input  logic                     STOP,
    input  logic [PATTERN_WIDTH-1:0] FIRST_PATTERN,
    input  logic [PATTERN_WIDTH-1:0] PATTERN_STEP,
    input  logic [1:0]               MODE,
    input  logic [31:0]              FRAME_COUNT,
    input  logic [15:0]              GAP_CYCLES,
    output logic [PATTERN_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                     AXIS_OUT_TVALID,
    input  logic                     AXIS_OUT_TREADY,
    output logic                     BUSY,
    output logic [31:0]              FRAMES_SENT
);

    localparam int unsigned PW = PATTERN_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
`ifdef SIMFRAME_SEQ_GAP_EN
    localparam logic [1:0] GAP  = 2'd2;
`endif

    logic [1:0]    state, state_nxt;
    logic [PW-1:0] tdata, tdata_nxt;
    logic          tvalid, tvalid_nxt;
    logic          busy, busy_nxt;
    logic [31:0]   frames, frames_nxt;
    logic          stop_req, stop_req_nxt;
    logic [PW-1:0] step_q, step_nxt;
    logic [1:0]    mode_q, mode_nxt;
    logic [31:0]   count_q, count_nxt;
    logic [PW-1:0] next_word;
    logic          last_frame;

`ifdef SIMFRAME_SEQ_GAP_EN
    logic [15:0]   gap_q, gap_nxt;
    logic [15:0]   gap_cnt, gap_cnt_nxt;
`else
    logic          unused_gap_cycles;
    assign unused_gap_cycles = ^GAP_CYCLES;
`endif

    // Next word of the sequence, derived from the word currently presented
    always_comb begin
        next_word = tdata;
        case (mode_q)
            2'd0:    next_word = tdata + step_q;
            2'd1:    next_word = {tdata[PW-2:0], tdata[PW-1]};
            2'd2:    next_word = ~tdata;
            default: next_word = tdata;
        endcase
    end

    // The 33-bit compare keeps a saturated counter from wrapping into a false match
    assign last_frame = (count_q != 32'd0) &&
                        (({1'b0, frames} + 33'd1) == {1'b0, count_q});

    // Next-state and output logic
    always_comb begin
        state_nxt    = state;
        tdata_nxt    = tdata;
        tvalid_nxt   = tvalid;
        busy_nxt     = busy;
        frames_nxt   = frames;
        stop_req_nxt = stop_req;
        step_nxt     = step_q;
        mode_nxt     = mode_q;
        count_nxt    = count_q;
`ifdef SIMFRAME_SEQ_GAP_EN
        gap_nxt      = gap_q;
        gap_cnt_nxt  = gap_cnt;
`endif
        case (state)
            IDLE: begin
                if (START && !STOP) begin
                    step_nxt     = PATTERN_STEP;
                    mode_nxt     = MODE;
                    count_nxt    = FRAME_COUNT;
`ifdef SIMFRAME_SEQ_GAP_EN
                    gap_nxt      = GAP_CYCLES;
`endif
                    tdata_nxt    = FIRST_PATTERN;
                    tvalid_nxt   = 1'b1;
                    busy_nxt     = 1'b1;
                    frames_nxt   = 32'd0;
                    stop_req_nxt = 1'b0;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                if (STOP) stop_req_nxt = 1'b1;
                if (AXIS_OUT_TREADY) begin
                    frames_nxt = (frames == 32'hFFFF_FFFF) ? frames : frames + 32'd1;
                    tdata_nxt  = next_word;
                    if (last_frame || stop_req || STOP) begin
                        tvalid_nxt   = 1'b0;
                        busy_nxt     = 1'b0;
                        stop_req_nxt = 1'b0;
                        state_nxt    = IDLE;
                    end
`ifdef SIMFRAME_SEQ_GAP_EN
                    else if (gap_q != 16'd0) begin
                        tvalid_nxt  = 1'b0;
                        gap_cnt_nxt = gap_q;
                        state_nxt   = GAP;
                    end
`endif
                end
            end
`ifdef SIMFRAME_SEQ_GAP_EN
            GAP: begin
                if (STOP) begin
                    busy_nxt     = 1'b0;
                    stop_req_nxt = 1'b0;
                    state_nxt    = IDLE;
                end else if (gap_cnt == 16'd1) begin
                    tvalid_nxt = 1'b1;
                    state_nxt  = SEND;
                end else begin
                    gap_cnt_nxt = gap_cnt - 16'd1;
                end
            end
`endif
            default: begin
                tvalid_nxt = 1'b0;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tdata    <= '0;
            tvalid   <= 1'b0;
            busy     <= 1'b0;
            frames   <= 32'd0;
            stop_req <= 1'b0;
            step_q   <= '0;
            mode_q   <= 2'd0;
            count_q  <= 32'd0;
`ifdef SIMFRAME_SEQ_GAP_EN
            gap_q    <= 16'd0;
            gap_cnt  <= 16'd0;
`endif
        end else begin
            state    <= state_nxt;
            tdata    <= tdata_nxt;
            tvalid   <= tvalid_nxt;
            busy     <= busy_nxt;
            frames   <= frames_nxt;
            stop_req <= stop_req_nxt;
            step_q   <= step_nxt;
            mode_q   <= mode_nxt;
            count_q  <= count_nxt;
`ifdef SIMFRAME_SEQ_GAP_EN
            gap_q    <= gap_nxt;
            gap_cnt  <= gap_cnt_nxt;
`endif
        end
    end

    assign AXIS_OUT_TDATA  = tdata;
    assign AXIS_OUT_TVALID = tvalid;
    assign BUSY            = busy;
    assign FRAMES_SENT     = frames;

endmodule

// File: tb/tb_simframe_pattern_seq.sv
// tb_simframe_pattern_seq
// Directed bench for simframe_pattern_seq (PATTERN_WIDTH=32). Inputs are driven 1 ns
// after each rising edge. Outputs are sampled at the same point.
module tb_simframe_pattern_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        START;
    logic        STOP;
    logic [31:0] FIRST_PATTERN;
    logic [31:0] PATTERN_STEP;
    logic [1:0]  MODE;
    logic [31:0] FRAME_COUNT;
    logic [15:0] GAP_CYCLES;
    logic [31:0] AXIS_OUT_TDATA;
    logic        AXIS_OUT_TVALID;
    logic        AXIS_OUT_TREADY;
    logic        BUSY;
    logic [31:0] FRAMES_SENT;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    simframe_pattern_seq #(.PATTERN_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .START           (START),
        .STOP            (STOP),
        .FIRST_PATTERN   (FIRST_PATTERN),
        .PATTERN_STEP    (PATTERN_STEP),
        .MODE            (MODE),
        .FRAME_COUNT     (FRAME_COUNT),
        .GAP_CYCLES      (GAP_CYCLES),
        .AXIS_OUT_TDATA  (AXIS_OUT_TDATA),
        .AXIS_OUT_TVALID (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY (AXIS_OUT_TREADY),
        .BUSY            (BUSY),
        .FRAMES_SENT     (FRAMES_SENT)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the data word, valid, busy and frame count together
    task automatic chk_out(input string tag, input logic [31:0] d, input logic v,
                           input logic b, input logic [31:0] f);
        chk({tag, ".tdata"},  64'(AXIS_OUT_TDATA),  64'(d));
        chk({tag, ".tvalid"}, 64'(AXIS_OUT_TVALID), 64'(v));
        chk({tag, ".busy"},   64'(BUSY),            64'(b));
        chk({tag, ".frames"}, 64'(FRAMES_SENT),     64'(f));
    endtask

    task automatic kick(input logic [31:0] first, input logic [31:0] stp, input logic [1:0] md,
                        input logic [31:0] cnt, input logic [15:0] gap);
        FIRST_PATTERN = first;
        PATTERN_STEP  = stp;
        MODE          = md;
        FRAME_COUNT   = cnt;
        GAP_CYCLES    = gap;
        START         = 1'b1;
        step();
        START         = 1'b0;
    endtask

    logic [9:0] vpat;

    initial begin
        reset = 1'b1; START = 1'b0; STOP = 1'b0; FIRST_PATTERN = '0; PATTERN_STEP = '0;
        MODE = 2'd0; FRAME_COUNT = '0; GAP_CYCLES = '0; AXIS_OUT_TREADY = 1'b0;
        step(); step();
        chk_out("reset", 32'h0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        step();

        // Test 1: mode 0 count, back-to-back; a config change after START must not matter
        AXIS_OUT_TREADY = 1'b1;
        kick(32'h10, 32'd1, 2'd0, 32'd4, 16'd0);
        PATTERN_STEP = 32'd5; FRAME_COUNT = 32'd9;
        chk_out("t1.w0", 32'h10, 1'b1, 1'b1, 32'd0);
        step(); chk_out("t1.w1", 32'h11, 1'b1, 1'b1, 32'd1);
        step(); chk_out("t1.w2", 32'h12, 1'b1, 1'b1, 32'd2);
        step(); chk_out("t1.w3", 32'h13, 1'b1, 1'b1, 32'd3);
        step();
        chk("t1.end.tvalid", 64'(AXIS_OUT_TVALID), 64'd0);
        chk("t1.end.busy",   64'(BUSY),            64'd0);
        chk("t1.end.frames", 64'(FRAMES_SENT),     64'd4);
        step();
        chk("t1.hold.frames", 64'(FRAMES_SENT), 64'd4);

        // Test 2: rotate-left with TREADY toggling
        AXIS_OUT_TREADY = 1'b0;
        kick(32'h8000_0001, 32'd0, 2'd1, 32'd3, 16'd0);
        chk_out("t2.w0", 32'h8000_0001, 1'b1, 1'b1, 32'd0);
        step(); chk_out("t2.w0.stall", 32'h8000_0001, 1'b1, 1'b1, 32'd0);
        AXIS_OUT_TREADY = 1'b1; step(); AXIS_OUT_TREADY = 1'b0;
        chk_out("t2.w1", 32'h0000_0003, 1'b1, 1'b1, 32'd1);
        step(); chk_out("t2.w1.stall", 32'h0000_0003, 1'b1, 1'b1, 32'd1);
        AXIS_OUT_TREADY = 1'b1; step(); AXIS_OUT_TREADY = 1'b0;
        chk_out("t2.w2", 32'h0000_0006, 1'b1, 1'b1, 32'd2);
        step(); chk_out("t2.w2.stall", 32'h0000_0006, 1'b1, 1'b1, 32'd2);
        AXIS_OUT_TREADY = 1'b1; step(); AXIS_OUT_TREADY = 1'b0;
        chk("t2.end.tvalid", 64'(AXIS_OUT_TVALID), 64'd0);
        chk("t2.end.frames", 64'(FRAMES_SENT),     64'd3);

        // Test 3: continuous invert, STOP raised while stalled
        AXIS_OUT_TREADY = 1'b1;
        kick(32'hA5A5_A5A5, 32'd0, 2'd2, 32'd0, 16'd0);
        chk_out("t3.w0", 32'hA5A5_A5A5, 1'b1, 1'b1, 32'd0);
        step(); chk_out("t3.w1", 32'h5A5A_5A5A, 1'b1, 1'b1, 32'd1);
        step(); chk_out("t3.w2", 32'hA5A5_A5A5, 1'b1, 1'b1, 32'd2);
        step(); step(); step();
        chk_out("t3.w5", 32'h5A5A_5A5A, 1'b1, 1'b1, 32'd5);
        AXIS_OUT_TREADY = 1'b0; STOP = 1'b1; step(); STOP = 1'b0;
        chk_out("t3.stopheld", 32'h5A5A_5A5A, 1'b1, 1'b1, 32'd5);
        step(); chk_out("t3.stopheld2", 32'h5A5A_5A5A, 1'b1, 1'b1, 32'd5);
        AXIS_OUT_TREADY = 1'b1; step();
        chk("t3.end.tvalid", 64'(AXIS_OUT_TVALID), 64'd0);
        chk("t3.end.busy",   64'(BUSY),            64'd0);
        chk("t3.end.frames", 64'(FRAMES_SENT),     64'd6);

        // Test 4: async reset mid-SEND with a pending word
        kick(32'h55, 32'd2, 2'd0, 32'd0, 16'd0);
        step(); AXIS_OUT_TREADY = 1'b0;
        chk_out("t4.pre", 32'h57, 1'b1, 1'b1, 32'd1);
        #2 reset = 1'b1;
        #1 chk_out("t4.async", 32'h0, 1'b0, 1'b0, 32'd0);
        step(); #3 reset = 1'b0;
        AXIS_OUT_TREADY = 1'b1;
        step(); step(); step();
        chk_out("t4.after", 32'h0, 1'b0, 1'b0, 32'd0);

        // Test 5: START+STOP together, STOP alone in IDLE, START while busy
        FIRST_PATTERN = 32'h77; FRAME_COUNT = 32'd2; START = 1'b1; STOP = 1'b1;
        step(); START = 1'b0; STOP = 1'b0;
        chk("t5.ss.busy",   64'(BUSY),            64'd0);
        chk("t5.ss.tvalid", 64'(AXIS_OUT_TVALID), 64'd0);
        STOP = 1'b1; step(); STOP = 1'b0;
        AXIS_OUT_TREADY = 1'b0;
        kick(32'h40, 32'd0, 2'd3, 32'd2, 16'd0);
        chk_out("t5.w0", 32'h40, 1'b1, 1'b1, 32'd0);
        kick(32'h99, 32'd1, 2'd0, 32'd1, 16'd0);
        chk_out("t5.reststart", 32'h40, 1'b1, 1'b1, 32'd0);
        AXIS_OUT_TREADY = 1'b1; step();
        chk_out("t5.w1", 32'h40, 1'b1, 1'b1, 32'd1);
        step();
        chk("t5.end.tvalid", 64'(AXIS_OUT_TVALID), 64'd0);
        chk("t5.end.frames", 64'(FRAMES_SENT),     64'd2);

        // Test 6: GAP_CYCLES=3 over three frames
        AXIS_OUT_TREADY = 1'b1;
        kick(32'h1, 32'd1, 2'd0, 32'd3, 16'd3);
        for (int i = 0; i < 10; i++) begin
            vpat[9-i] = AXIS_OUT_TVALID;
            step();
        end
`ifdef SIMFRAME_SEQ_GAP_EN
        chk("t6.gap.pattern", 64'(vpat), 64'(10'b1000100010));
`else
        chk("t6.nogap.pattern", 64'(vpat), 64'(10'b1110000000));
`endif
        chk("t6.frames", 64'(FRAMES_SENT), 64'd3);
        chk("t6.tdata",  64'(AXIS_OUT_TDATA), 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
